bus_err_log_writer: RTL and testbench

BUS_ERR_LOG_WRITER -- requirements
Module: bus_err_log_writer

---
 rtl/bus_err_log_writer.sv | 177 +++++++++++++++++
 tb/tb_bus_err_log_writer.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_err_log_writer.sv
// Purpose: drains an error FIFO into a memory-resident ring of log records and raises a coalesced interrupt.
// Latency: the record is latched in the pop cycle, and mem_req is asserted from the next cycle; at most one record per 2 cycles.
// Backpressure: mem_req is held with a stable address and data until mem_gnt; a full ring drops the error and counts it.
module bus_err_log_writer #(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned MetaDataWidth = 1,
    parameter int unsigned ErrBits       = 3,
    parameter int unsigned LogDepth      = 16,
    parameter int unsigned LogAddrWidth  = 32,
    parameter int unsigned EntryStride   = 16,
    parameter int unsigned CntWidth      = 16,
    parameter int unsigned TimeoutWidth  = 16,
    localparam int unsigned PW = $clog2(LogDepth) + 1,
    localparam int unsigned RW = 1 + ErrBits + AddrWidth + MetaDataWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    err_irq_i,
    input  logic [ErrBits-1:0]      err_code_i,
    input  logic [AddrWidth-1:0]    err_addr_i,
    input  logic [MetaDataWidth-1:0] err_meta_i,
    input  logic                    err_fifo_overflow_i,
    output logic                    err_fifo_pop_o,
    input  logic                    enable_i,
    input  logic [LogAddrWidth-1:0] log_base_i,
    input  logic [PW-1:0]           rd_ptr_i,
    input  logic [CntWidth-1:0]     coalesce_thresh_i,
    input  logic [TimeoutWidth-1:0] coalesce_timeout_i,
    input  logic                    irq_clear_i,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [LogAddrWidth-1:0] mem_addr_o,
    output logic [RW-1:0]           mem_wdata_o,
    output logic [PW-1:0]           wr_ptr_o,
    output logic [CntWidth-1:0]     total_cnt_o,
    output logic [CntWidth-1:0]     drop_cnt_o,
    output logic                    irq_o
);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic                    pop_blk_q;
    logic                    pop, capture, drop, done;
    logic                    ovf_q;
    logic [RW-1:0]           rec_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [CntWidth-1:0]     total_q, drop_q, pending_q;
    logic [TimeoutWidth-1:0] timer_q, timer_inc;
    logic                    irq_q;
    logic [PW-1:0]           fill;
    logic                    full;
    logic [PW-2:0]           slot;
    logic [CntWidth-1:0]     thresh_eff, pending_inc;
    logic                    timer_run, thresh_hit, timer_hit;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + CntWidth'(1);
    endfunction

    // Ring occupancy uses the free-running pointers, so a difference of exactly LogDepth means full.
    assign fill = wr_ptr_q - rd_ptr_i;
    assign full = (fill == PW'(LogDepth));
    assign slot = wr_ptr_q[PW-2:0];

    // Next-state and handshake decode; pop_blk_q keeps two pops from landing on adjacent cycles.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        drop    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (err_irq_i && enable_i && !pop_blk_q) begin
                    pop = 1'b1;
                    if (full) begin
                        drop = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (mem_gnt_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; the pop guard comes out of reset set so no pop can appear while reset is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pop_blk_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            pop_blk_q <= pop;
        end
    end

    // Latch the head record; the overflow flag rides in the record and restarts from this cycle's overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rec_q <= '0;
            ovf_q <= 1'b0;
        end else if (capture) begin
            rec_q <= {ovf_q, err_code_i, err_addr_i, err_meta_i};
            ovf_q <= err_fifo_overflow_i;
        end else begin
            ovf_q <= ovf_q | err_fifo_overflow_i;
        end
    end

    // Write pointer advances only on grant; the record and drop counters saturate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            total_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (done) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                total_q  <= sat_inc(total_q);
            end
            if (drop) begin
                drop_q <= sat_inc(drop_q);
            end
        end
    end

    // Coalescing: the threshold is checked on each completed write, and the timer runs only while work is unreported.
    assign thresh_eff  = (coalesce_thresh_i == '0) ? CntWidth'(1) : coalesce_thresh_i;
    assign pending_inc = sat_inc(pending_q);
    assign timer_inc   = (&timer_q) ? timer_q : timer_q + TimeoutWidth'(1);
    assign timer_run   = (pending_q != '0) && !irq_q && (coalesce_timeout_i != '0);
    assign thresh_hit  = done && (pending_inc >= thresh_eff);
    assign timer_hit   = timer_run && (timer_inc >= coalesce_timeout_i);

    // Pending, timer and IRQ state; an acknowledge beats every set source except a drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            timer_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (irq_clear_i) begin
                pending_q <= done ? CntWidth'(1) : '0;
                timer_q   <= '0;
            end else begin
                if (done)      pending_q <= pending_inc;
                if (timer_run) timer_q   <= timer_inc;
            end
            if (drop) begin
                irq_q <= 1'b1;
            end else if (irq_clear_i) begin
                irq_q <= 1'b0;
            end else if (thresh_hit || timer_hit) begin
                irq_q <= 1'b1;
            end
        end
    end

    assign err_fifo_pop_o = pop;
    assign mem_req_o      = (state_q == WRITE);
    assign mem_addr_o     = log_base_i + LogAddrWidth'(slot) * LogAddrWidth'(EntryStride);
    assign mem_wdata_o    = rec_q;
    assign wr_ptr_o       = wr_ptr_q;
    assign total_cnt_o    = total_q;
    assign drop_cnt_o     = drop_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_bus_err_log_writer.sv
// Purpose: randomized and directed checks of bus_err_log_writer against a scoreboard of expected ring writes.
// Latency: inputs change 1 time unit after the rising edge, and outputs are sampled on the falling edge.
// Backpressure: the grant is randomized or held low to exercise a request that stays pending.
module tb_bus_err_log_writer;

    localparam int RW = 53;

    typedef struct {
        logic [2:0]  code;
        logic [47:0] addr;
        logic [0:0]  meta;
    } err_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          err_irq_i = 1'b0;
    logic [2:0]    err_code_i = '0;
    logic [47:0]   err_addr_i = '0;
    logic [0:0]    err_meta_i = '0;
    logic          err_fifo_overflow_i = 1'b0;
    logic          err_fifo_pop_o;
    logic          enable_i = 1'b0;
    logic [31:0]   log_base_i = '0;
    logic [4:0]    rd_ptr_i = '0;
    logic [15:0]   coalesce_thresh_i = 16'd1;
    logic [15:0]   coalesce_timeout_i = '0;
    logic          irq_clear_i = 1'b0;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b0;
    logic [31:0]   mem_addr_o;
    logic [RW-1:0] mem_wdata_o;
    logic [4:0]    wr_ptr_o;
    logic [15:0]   total_cnt_o;
    logic [15:0]   drop_cnt_o;
    logic          irq_o;

    bus_err_log_writer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .err_irq_i(err_irq_i), .err_code_i(err_code_i),
        .err_addr_i(err_addr_i), .err_meta_i(err_meta_i), .err_fifo_overflow_i(err_fifo_overflow_i),
        .err_fifo_pop_o(err_fifo_pop_o), .enable_i(enable_i), .log_base_i(log_base_i),
        .rd_ptr_i(rd_ptr_i), .coalesce_thresh_i(coalesce_thresh_i),
        .coalesce_timeout_i(coalesce_timeout_i), .irq_clear_i(irq_clear_i), .mem_req_o(mem_req_o),
        .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .wr_ptr_o(wr_ptr_o), .total_cnt_o(total_cnt_o), .drop_cnt_o(drop_cnt_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    err_t          fifo_q[$];
    logic [RW-1:0] exp_q[$];
    logic [31:0]   wr_addr_log[$];
    logic [RW-1:0] wr_data_log[$];
    int            n_writes, n_drops, n_checks, n_fail;
    logic          ovf_m, prev_pop;
    logic          s_pop, s_req;
    logic [31:0]   s_addr;
    logic [RW-1:0] s_wdata;

    task automatic drive_head();
        if (fifo_q.size() > 0) begin
            err_irq_i  = 1'b1;
            err_code_i = fifo_q[0].code;
            err_addr_i = fifo_q[0].addr;
            err_meta_i = fifo_q[0].meta;
        end else begin
            err_irq_i  = 1'b0;
            err_code_i = '0;
            err_addr_i = '0;
            err_meta_i = '0;
        end
    endtask

    task automatic push_err(input logic [2:0] code, input logic [47:0] addr, input logic [0:0] meta);
        err_t e;
        e.code = code;
        e.addr = addr;
        e.meta = meta;
        fifo_q.push_back(e);
        drive_head();
    endtask

    // One clock: sample at the falling edge, score pops and writes, then advance the error FIFO model.
    task automatic cyc();
        logic          full;
        logic [31:0]   exp_addr;
        logic [RW-1:0] exp_d;
        @(negedge clk_i);
        s_pop   = err_fifo_pop_o;
        s_req   = mem_req_o;
        s_addr  = mem_addr_o;
        s_wdata = mem_wdata_o;
        n_checks++;
        if (s_pop && !err_irq_i) begin
            n_fail++;
            $display("FAIL pop_without_irq: pop=%0b err_irq=%0b, required no pop", s_pop, err_irq_i);
        end
        n_checks++;
        if (s_pop && (prev_pop || s_req || !enable_i)) begin
            n_fail++;
            $display("FAIL pop_illegal: prev_pop=%0b req=%0b enable=%0b, required no pop", prev_pop, s_req, enable_i);
        end
        if (s_pop) begin
            full = (((n_writes - int'(rd_ptr_i)) & 31) == 16);
            if (full) begin
                n_drops++;
                ovf_m = ovf_m | err_fifo_overflow_i;
            end else begin
                exp_q.push_back({ovf_m, err_code_i, err_addr_i, err_meta_i});
                ovf_m = err_fifo_overflow_i;
            end
        end else begin
            ovf_m = ovf_m | err_fifo_overflow_i;
        end
        if (s_req && mem_gnt_i) begin
            exp_addr = log_base_i + 32'((n_writes % 16) * 16);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", s_addr, s_wdata);
            end else begin
                exp_d = exp_q.pop_front();
                n_checks++;
                if (s_addr !== exp_addr || s_wdata !== exp_d) begin
                    n_fail++;
                    $display("FAIL write_content: addr=%h data=%h, required addr=%h data=%h", s_addr, s_wdata, exp_addr, exp_d);
                end
            end
            wr_addr_log.push_back(s_addr);
            wr_data_log.push_back(s_wdata);
            n_writes++;
        end
        prev_pop = s_pop;
        @(posedge clk_i);
        #1;
        if (s_pop && fifo_q.size() > 0) fifo_q.delete(0);
        drive_head();
        n_checks++;
        if (wr_ptr_o !== 5'(n_writes) || total_cnt_o !== 16'(n_writes) || drop_cnt_o !== 16'(n_drops)) begin
            n_fail++;
            $display("FAIL counters: wr_ptr=%0d total=%0d drop=%0d, required %0d %0d %0d", wr_ptr_o, total_cnt_o, drop_cnt_o, 5'(n_writes), n_writes, n_drops);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        n_writes = 0;
        n_drops  = 0;
        ovf_m    = 1'b0;
        prev_pop = 1'b0;
        drive_head();
        enable_i = 1'b1;
        mem_gnt_i = 1'b0;
        irq_clear_i = 1'b0;
        err_fifo_overflow_i = 1'b0;
        rd_ptr_i = '0;
        log_base_i = '0;
        coalesce_thresh_i = 16'd1;
        coalesce_timeout_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic run_until_writes(input int target, input int budget);
        int k;
        k = 0;
        while (n_writes < target && k < budget) begin
            cyc();
            k++;
        end
        n_checks++;
        if (n_writes < target) begin
            n_fail++;
            $display("FAIL write_timeout: writes=%0d, required %0d", n_writes, target);
        end
    endtask

    task automatic test_reset();
        #2;
        rst_ni = 1'b0;
        err_irq_i = 1'b1;
        enable_i = 1'b1;
        #20;
        n_checks++;
        if (err_fifo_pop_o !== 1'b0 || mem_req_o !== 1'b0 || irq_o !== 1'b0 || wr_ptr_o !== 5'd0 ||
            total_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0 || mem_wdata_o !== '0) begin
            n_fail++;
            $display("FAIL reset_values: pop=%b req=%b irq=%b wr_ptr=%0d total=%0d drop=%0d wdata=%h, required all zero",
                     err_fifo_pop_o, mem_req_o, irq_o, wr_ptr_o, total_cnt_o, drop_cnt_o, mem_wdata_o);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [RW-1:0] exp_rec;
        do_reset();
        log_base_i = 32'h8000_0000;
        exp_rec = {1'b0, 3'd3, 48'h1000, 1'b0};
        push_err(3'd3, 48'h1000, 1'b0);
        cyc();
        n_checks++;
        if (s_pop !== 1'b1 || s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c0: pop=%b req=%b, required pop=1 req=0", s_pop, s_req);
        end
        cyc();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h8000_0000 || s_wdata !== exp_rec) begin
            n_fail++;
            $display("FAIL single_c1: req=%b addr=%h data=%h, required 1 80000000 %h", s_req, s_addr, s_wdata, exp_rec);
        end
        cyc();
        mem_gnt_i = 1'b1;
        n_checks++;
        if (s_req !== 1'b1 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c2: req=%b irq=%b, required req=1 irq=0", s_req, irq_o);
        end
        cyc();
        mem_gnt_i = 1'b0;
        n_checks++;
        if (wr_ptr_o !== 5'd1 || irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_c4: wr_ptr=%0d irq=%b, required wr_ptr=1 irq=1", wr_ptr_o, irq_o);
        end
        cyc();
        n_checks++;
        if (s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: req=%b, required 0", s_req);
        end
    endtask

    task automatic test_fill_drop();
        int k;
        do_reset();
        log_base_i = 32'h0001_0000;
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 17; i++) push_err(3'(i), 48'(i * 64 + 4), 1'(i));
        k = 0;
        while (fifo_q.size() > 0 && k < 100) begin
            cyc();
            k++;
        end
        repeat (3) cyc();
        n_checks++;
        if (n_writes != 16 || drop_cnt_o !== 16'd1 || wr_ptr_o !== 5'd16 || irq_o !== 1'b1 || fifo_q.size() != 0) begin
            n_fail++;
            $display("FAIL fill_drop: writes=%0d drop=%0d wr_ptr=%0d irq=%b left=%0d, required 16 1 16 1 0",
                     n_writes, drop_cnt_o, wr_ptr_o, irq_o, fifo_q.size());
        end
        n_checks++;
        if (wr_addr_log.size() < 16 || wr_addr_log[15] !== 32'h0001_00F0) begin
            n_fail++;
            $display("FAIL slot15_addr: logged=%0d, required slot 15 at 000100f0", wr_addr_log.size());
        end
        mem_gnt_i = 1'b0;
    endtask

    task automatic test_timeout();
        int start;
        logic exp_irq;
        do_reset();
        coalesce_thresh_i = 16'd4;
        coalesce_timeout_i = 16'd10;
        mem_gnt_i = 1'b1;
        push_err(3'd1, 48'hA0, 1'b0);
        push_err(3'd2, 48'hB0, 1'b1);
        start = -1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (start < 0 && wr_ptr_o != 5'd0) start = i;
            if (start >= 0) begin
                exp_irq = ((i - start) >= 10);
                n_checks++;
                if (irq_o !== exp_irq) begin
                    n_fail++;
                    $display("FAIL timeout_irq: %0d cycles after pending=1 irq=%b, required %b", i - start, irq_o, exp_irq);
                end
            end
        end
        n_checks++;
        if (start < 0 || n_writes != 2) begin
            n_fail++;
            $display("FAIL timeout_writes: writes=%0d, required 2", n_writes);
        end
        mem_gnt_i = 1'b0;
    endtask

    task automatic test_ovf();
        do_reset();
        mem_gnt_i = 1'b1;
        err_fifo_overflow_i = 1'b1;
        cyc();
        err_fifo_overflow_i = 1'b0;
        cyc();
        push_err(3'd5, 48'h2222, 1'b1);
        push_err(3'd6, 48'h3333, 1'b0);
        run_until_writes(2, 40);
        n_checks++;
        if (wr_data_log.size() != 2 || wr_data_log[0][RW-1] !== 1'b1 || wr_data_log[1][RW-1] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_bit: logged=%0d, required MSB 1 then 0", wr_data_log.size());
        end
        mem_gnt_i = 1'b0;
    endtask

    task automatic test_wrap();
        int k;
        do_reset();
        log_base_i = 32'h0000_4000;
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 31; i++) push_err(3'(i), 48'(i), 1'b0);
        k = 0;
        while (n_writes < 31 && k < 200) begin
            rd_ptr_i = 5'(n_writes);
            cyc();
            k++;
        end
        n_checks++;
        if (wr_ptr_o !== 5'd31) begin
            n_fail++;
            $display("FAIL wrap_pre: wr_ptr=%0d, required 31", wr_ptr_o);
        end
        rd_ptr_i = 5'd16;
        push_err(3'd7, 48'hFFFF, 1'b1);
        run_until_writes(32, 20);
        n_checks++;
        if (wr_ptr_o !== 5'd0 || wr_addr_log.size() != 32 || wr_addr_log[31] !== 32'h0000_40F0) begin
            n_fail++;
            $display("FAIL wrap: wr_ptr=%0d logged=%0d, required wr_ptr=0 last addr 000040f0", wr_ptr_o, wr_addr_log.size());
        end
        mem_gnt_i = 1'b0;
    endtask

    task automatic test_clear_grant();
        int k;
        logic [RW-1:0] exp_rec;
        do_reset();
        log_base_i = 32'h0000_2000;
        mem_gnt_i = 1'b1;
        push_err(3'd1, 48'h10, 1'b0);
        run_until_writes(1, 20);
        cyc();
        n_checks++;
        if (irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_pre_irq: irq=%b, required 1", irq_o);
        end
        mem_gnt_i = 1'b0;
        exp_rec = {1'b0, 3'd4, 48'hCAFE, 1'b1};
        push_err(3'd4, 48'hCAFE, 1'b1);
        k = 0;
        s_pop = 1'b0;
        while (!s_pop && k < 10) begin
            cyc();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h0000_2010 || s_wdata !== exp_rec) begin
                n_fail++;
                $display("FAIL hold_stable: req=%b addr=%h data=%h, required 1 00002010 %h", s_req, s_addr, s_wdata, exp_rec);
            end
        end
        mem_gnt_i = 1'b1;
        irq_clear_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        irq_clear_i = 1'b0;
        n_checks++;
        if (irq_o !== 1'b0 || wr_ptr_o !== 5'd2) begin
            n_fail++;
            $display("FAIL clr_grant: irq=%b wr_ptr=%0d, required irq=0 wr_ptr=2", irq_o, wr_ptr_o);
        end
        coalesce_timeout_i = 16'd3;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (irq_o !== (j == 3)) begin
                n_fail++;
                $display("FAIL pending_one: cycle %0d irq=%b, required %b", j, irq_o, (j == 3));
            end
            if (j < 3) cyc();
        end
    endtask

    task automatic test_mid_write_reset();
        int k;
        do_reset();
        mem_gnt_i = 1'b1;
        push_err(3'd2, 48'h44, 1'b0);
        run_until_writes(1, 20);
        mem_gnt_i = 1'b0;
        push_err(3'd3, 48'h55, 1'b0);
        k = 0;
        s_req = 1'b0;
        while (!s_req && k < 10) begin
            cyc();
            k++;
        end
        rst_ni = 1'b0;
        #2;
        n_checks++;
        if (mem_req_o !== 1'b0 || wr_ptr_o !== 5'd0 || irq_o !== 1'b0 || total_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_in_write: req=%b wr_ptr=%0d irq=%b total=%0d, required all zero", mem_req_o, wr_ptr_o, irq_o, total_cnt_o);
        end
        do_reset();
        repeat (3) cyc();
    endtask

    task automatic test_random();
        int k;
        do_reset();
        log_base_i = $urandom & 32'hFFFF_FFF0;
        coalesce_thresh_i = 16'($urandom_range(1, 8));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8)
                push_err(3'($urandom), {16'($urandom), 32'($urandom)}, 1'($urandom));
            enable_i = ($urandom_range(0, 7) != 0);
            mem_gnt_i = 1'($urandom_range(0, 1));
            err_fifo_overflow_i = ($urandom_range(0, 15) == 0);
            irq_clear_i = ($urandom_range(0, 20) == 0);
            if ($urandom_range(0, 5) == 0 && rd_ptr_i != 5'(n_writes)) rd_ptr_i = rd_ptr_i + 5'd1;
            cyc();
        end
        enable_i = 1'b1;
        mem_gnt_i = 1'b1;
        err_fifo_overflow_i = 1'b0;
        irq_clear_i = 1'b0;
        k = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0) && k < 200) begin
            rd_ptr_i = 5'(n_writes);
            cyc();
            k++;
        end
        n_checks++;
        if (fifo_q.size() != 0 || exp_q.size() != 0 || n_writes == 0) begin
            n_fail++;
            $display("FAIL random_drain: fifo=%0d outstanding=%0d writes=%0d, required 0 0 nonzero", fifo_q.size(), exp_q.size(), n_writes);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_fill_drop();
        test_timeout();
        test_ovf();
        test_wrap();
        test_clear_grant();
        test_mid_write_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
